// File: rtl/soc_io_pkg.sv
// Shared types and constants for the IO peripheral bus controller and its decoder.
package soc_io_pkg;

  typedef enum logic [1:0] {
    IO_IDLE,
    IO_SETUP,
    IO_STROBE,
    IO_HOLD
  } io_state_t;

  typedef enum logic {
    IO_DIR_RD,
    IO_DIR_WR
  } io_dir_t;

  localparam logic [3:0]  IO_PORT_A        = 4'h0;
  localparam logic [3:0]  IO_UART          = 4'h1;
  localparam logic [31:0] IO_TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/io_dev_decode.sv
// Device index to one-hot-low chip select decode, with a flag for mapped indices.
module io_dev_decode #(
  parameter int NUM_DEV = 16
) (
  input  logic [3:0]         idx,
  output logic [NUM_DEV-1:0] cs_n,
  output logic               valid
);

  always_comb begin
    cs_n  = '1;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (idx == 4'(i)) begin
        cs_n[i] = 1'b0;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// Sequences CPU IO accesses onto the byte-wide strobed peripheral bus.
// Optional strobe timeout/abort with sticky bus_err: define IO_BUS_TIMEOUT_EN.
module io_bus_ctrl
  import soc_io_pkg::*;
#(
  parameter int NUM_DEV        = 16,
  parameter int WAIT_STATES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_sel,
  input  logic [7:0]           addr,
  input  logic [3:0]           wmask,
  input  logic [31:0]          wdata,
  input  logic                 rstrb,
  output logic [31:0]          rdata,
  output logic                 rbusy,
  output logic                 wbusy,
  output logic [NUM_DEV-1:0]   dev_cs_n,
  output logic [3:0]           dev_addr,
  output logic [7:0]           dev_wdata,
  output logic                 dev_rd_n,
  output logic                 dev_wr_n,
  input  logic [NUM_DEV*8-1:0] dev_rdata,
  input  logic                 dev_ready,
  output logic                 bus_err
);

  io_state_t          state_q, state_d;
  io_dir_t            dir_q, dir_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [NUM_DEV-1:0] cs_dec_n;
  logic               dev_valid;
  logic [7:0]         rd_byte;
  logic               unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  // Decode from the next-cycle address so the registered cs lines up with SETUP.
  io_dev_decode #(.NUM_DEV(NUM_DEV)) u_decode (
    .idx   (addr_d[7:4]),
    .cs_n  (cs_dec_n),
    .valid (dev_valid)
  );

  always_comb begin
    rd_byte = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (addr_q[7:4] == 4'(i)) rd_byte = dev_rdata[8*i +: 8];
    end
  end

`ifdef IO_BUS_TIMEOUT_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef IO_BUS_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IO_IDLE: begin
        if (io_sel && (wmask != 4'b0000)) begin
          dir_d   = IO_DIR_WR;
          addr_d  = addr;
          wdata_d = wdata[7:0];
          state_d = IO_SETUP;
        end else if (io_sel && rstrb) begin
          dir_d   = IO_DIR_RD;
          addr_d  = addr;
          state_d = IO_SETUP;
        end
      end
      IO_SETUP: begin
        cnt_d   = '0;
        state_d = IO_STROBE;
      end
      IO_STROBE: begin
        if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
        if (dev_ready && (int'(cnt_q) >= WAIT_STATES - 1)) begin
          state_d = IO_HOLD;
          if (dir_q == IO_DIR_RD) rdata_d = dev_valid ? {24'b0, rd_byte} : '0;
        end
`ifdef IO_BUS_TIMEOUT_EN
        else if (!dev_ready && (int'(cnt_q) >= TIMEOUT_CYCLES - 1)) begin
          state_d = IO_HOLD;
          err_d   = 1'b1;
          if (dir_q == IO_DIR_RD) rdata_d = IO_TIMEOUT_RDATA;
        end
`endif
      end
      IO_HOLD: state_d = IO_IDLE;
      default: state_d = IO_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they track the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IO_IDLE;
      dir_q    <= IO_DIR_RD;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      dev_cs_n <= '1;
      dev_rd_n <= 1'b1;
      dev_wr_n <= 1'b1;
      rbusy    <= 1'b0;
      wbusy    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      dev_cs_n <= (state_d != IO_IDLE) ? cs_dec_n : '1;
      dev_rd_n <= !((state_d == IO_STROBE) && (dir_d == IO_DIR_RD));
      dev_wr_n <= !((state_d == IO_STROBE) && (dir_d == IO_DIR_WR));
      rbusy    <= (state_d != IO_IDLE) && (dir_d == IO_DIR_RD);
      wbusy    <= (state_d != IO_IDLE) && (dir_d == IO_DIR_WR);
    end
  end

`ifdef IO_BUS_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign rdata     = rdata_q;
  assign dev_addr  = addr_q[3:0];
  assign dev_wdata = wdata_q;

endmodule
